// File: rtl/clk_sys_rst_seq.sv
// Power-up / re-lock sequencer for the clk_sys clock wizard: holds the wizard in reset,
// waits for a qualified lock with bounded retries, then releases the three domain resets in order.
module clk_sys_rst_seq #(
    parameter int unsigned RST_CYCLES    = 64,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned STAGGER       = 16,
    parameter int unsigned MAX_RETRY     = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic       clk_in1,
    input  logic       reset,
    input  logic       reinit,
    input  logic       locked,
    output logic       mmcm_reset,
    output logic       rst_out1,
    output logic       rst_out2,
    output logic       rst_out3,
    output logic       pll_ok,
    output logic       lock_lost,
    output logic       fault,
    output logic [3:0] retry_cnt
);

    localparam int unsigned RETRY_W = 4;
    localparam int unsigned NUM_DOM = 3;

    localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STAG_LAST = CNT_W'(STAGGER - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_RST,
        ST_WAIT_LOCK,
        ST_STAB,
        ST_REL1,
        ST_REL2,
        ST_REL3,
        ST_RUN,
        ST_FAULT
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           sync_q;
    logic                 mmcm_reset_q, mmcm_reset_d;
    logic [NUM_DOM-1:0]   rst_out_q, rst_out_d;
    logic                 pll_ok_q, pll_ok_d;
    logic                 lock_lost_q, lock_lost_d;
    logic                 fault_q, fault_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [RETRY_W-1:0]   retry_inc;
    logic                 locked_s;
    logic                 released;

    assign locked_s  = sync_q[1];
    assign released  = (state_q == ST_REL1) || (state_q == ST_REL2) ||
                       (state_q == ST_REL3) || (state_q == ST_RUN);
    assign retry_inc = retry_q + RETRY_W'(1);

    // State, counter, lock synchronizer and registered outputs
    always_ff @(posedge clk_in1) begin
        if (reset) begin
            state_q      <= ST_RST;
            cnt_q        <= '0;
            sync_q       <= '0;
            mmcm_reset_q <= 1'b1;
            rst_out_q    <= '1;
            pll_ok_q     <= 1'b0;
            lock_lost_q  <= 1'b0;
            fault_q      <= 1'b0;
            retry_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sync_q       <= {sync_q[0], locked};
            mmcm_reset_q <= mmcm_reset_d;
            rst_out_q    <= rst_out_d;
            pll_ok_q     <= pll_ok_d;
            lock_lost_q  <= lock_lost_d;
            fault_q      <= fault_d;
            retry_q      <= retry_d;
        end
    end

    // Next state and next output values; reinit beats lock loss beats timers
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mmcm_reset_d = mmcm_reset_q;
        rst_out_d    = rst_out_q;
        pll_ok_d     = pll_ok_q;
        lock_lost_d  = 1'b0;
        fault_d      = fault_q;
        retry_d      = retry_q;

        if (reinit) begin
            state_d      = ST_RST;
            cnt_d        = '0;
            mmcm_reset_d = 1'b1;
            rst_out_d    = '1;
            pll_ok_d     = 1'b0;
            fault_d      = 1'b0;
            retry_d      = '0;
        end else if (released && !locked_s) begin
            state_d     = ST_RST;
            cnt_d       = '0;
            rst_out_d   = '1;
            pll_ok_d    = 1'b0;
            lock_lost_d = 1'b1;
        end else begin
            case (state_q)
                ST_RST: begin
                    // After a lock loss mmcm_reset rises one cycle late; count only while it is high
                    mmcm_reset_d = 1'b1;
                    if (mmcm_reset_q) begin
                        if (cnt_q == RST_LAST) begin
                            state_d      = ST_WAIT_LOCK;
                            cnt_d        = '0;
                            mmcm_reset_d = 1'b0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = ST_STAB;
                        cnt_d   = '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        cnt_d        = '0;
                        retry_d      = retry_inc;
                        mmcm_reset_d = 1'b1;
                        if (retry_inc == RETRY_MAX) begin
                            state_d = ST_FAULT;
                            fault_d = 1'b1;
                        end else begin
                            state_d = ST_RST;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_STAB: begin
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STAB_LAST) begin
                        state_d      = ST_REL1;
                        cnt_d        = '0;
                        rst_out_d[0] = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_REL1, ST_REL2, ST_REL3: begin
                    if (cnt_q == STAG_LAST) begin
                        cnt_d = '0;
                        if (state_q == ST_REL1) begin
                            state_d      = ST_REL2;
                            rst_out_d[1] = 1'b0;
                        end else if (state_q == ST_REL2) begin
                            state_d      = ST_REL3;
                            rst_out_d[2] = 1'b0;
                        end else begin
                            state_d  = ST_RUN;
                            pll_ok_d = 1'b1;
                            retry_d  = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    assign mmcm_reset = mmcm_reset_q;
    assign rst_out1   = rst_out_q[0];
    assign rst_out2   = rst_out_q[1];
    assign rst_out3   = rst_out_q[2];
    assign pll_ok     = pll_ok_q;
    assign lock_lost  = lock_lost_q;
    assign fault      = fault_q;
    assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_clk_sys_rst_seq.sv
// Directed bench for clk_sys_rst_seq with short timing parameters; expected cycle
// counts are hand-derived (locked reaches the FSM three edges after it changes).
module tb_clk_sys_rst_seq;

    logic       clk_in1;
    logic       reset;
    logic       reinit;
    logic       locked;
    logic       mmcm_reset;
    logic       rst_out1;
    logic       rst_out2;
    logic       rst_out3;
    logic       pll_ok;
    logic       lock_lost;
    logic       fault;
    logic [3:0] retry_cnt;

    int n_cmp;
    int n_bad;

    localparam logic [10:0] RESET_VEC = 11'b1_111_0_0_0_0000;

    clk_sys_rst_seq #(
        .RST_CYCLES   (8),
        .LOCK_TIMEOUT (64),
        .STABLE_CYCLES(16),
        .STAGGER      (4),
        .MAX_RETRY    (3),
        .CNT_W        (16)
    ) dut (
        .clk_in1   (clk_in1),
        .reset     (reset),
        .reinit    (reinit),
        .locked    (locked),
        .mmcm_reset(mmcm_reset),
        .rst_out1  (rst_out1),
        .rst_out2  (rst_out2),
        .rst_out3  (rst_out3),
        .pll_ok    (pll_ok),
        .lock_lost (lock_lost),
        .fault     (fault),
        .retry_cnt (retry_cnt)
    );

    initial clk_in1 = 1'b0;
    always #5 clk_in1 = ~clk_in1;

    task automatic step();
        @(posedge clk_in1);
        #1;
    endtask

    function automatic logic [10:0] outs();
        return {mmcm_reset, rst_out1, rst_out2, rst_out3, pll_ok, lock_lost, fault, retry_cnt};
    endfunction

    function automatic int get_sig(input int sel);
        case (sel)
            0:       return int'(mmcm_reset);
            1:       return int'(rst_out1);
            2:       return int'(rst_out2);
            3:       return int'(rst_out3);
            4:       return int'(pll_ok);
            5:       return int'(fault);
            default: return int'(retry_cnt);
        endcase
    endfunction

    // Steps until the selected output equals val; n = edges taken, -1 if the budget runs out
    task automatic wait_for(input int sel, input int val, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (get_sig(sel) == val) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; reinit = 1'b0; locked = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (outs() !== RESET_VEC) begin
            n_bad++; $display("FAIL reset_values: got %b want %b", outs(), RESET_VEC);
        end
        reset = 1'b0;
    endtask

    task automatic test_power_up();
        int n;
        wait_for(0, 0, 100, n);
        n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL pu_mmcm_hold: got %0d want 8", n); end
        repeat (3) step();
        locked = 1'b1;
        wait_for(1, 0, 100, n);
        n_cmp++; if (n !== 19) begin n_bad++; $display("FAIL pu_rel1: got %0d want 19", n); end
        n_cmp++;
        if ({rst_out2, rst_out3, pll_ok} !== 3'b110) begin
            n_bad++; $display("FAIL pu_rel1_only: got %b want 110", {rst_out2, rst_out3, pll_ok});
        end
        wait_for(2, 0, 100, n);
        n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL pu_rel2: got %0d want 4", n); end
        wait_for(3, 0, 100, n);
        n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL pu_rel3: got %0d want 4", n); end
        wait_for(4, 1, 100, n);
        n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL pu_run: got %0d want 4", n); end
        n_cmp++;
        if (outs() !== 11'b0_000_1_0_0_0000) begin
            n_bad++; $display("FAIL pu_run_outs: got %b want 00001000000", outs());
        end
    endtask

    task automatic test_retry_fault();
        int n;
        reset = 1'b1; locked = 1'b0;
        step();
        reset = 1'b0;
        wait_for(0, 0, 100, n);
        n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL rf_hold0: got %0d want 8", n); end
        for (int r = 1; r <= 2; r++) begin
            wait_for(6, r, 200, n);
            n_cmp++;
            if (n !== 64) begin n_bad++; $display("FAIL rf_window%0d: got %0d want 64", r, n); end
            n_cmp++;
            if ({mmcm_reset, fault} !== 2'b10) begin
                n_bad++; $display("FAIL rf_retry%0d_state: got %b want 10", r, {mmcm_reset, fault});
            end
            wait_for(0, 0, 100, n);
            n_cmp++;
            if (n !== 8) begin n_bad++; $display("FAIL rf_hold%0d: got %0d want 8", r, n); end
        end
        wait_for(5, 1, 200, n);
        n_cmp++; if (n !== 64) begin n_bad++; $display("FAIL rf_window3: got %0d want 64", n); end
        n_cmp++;
        if (outs() !== 11'b1_111_0_0_1_0011) begin
            n_bad++; $display("FAIL rf_fault_outs: got %b want 11110000011", outs());
        end
        repeat (10) step();
        n_cmp++;
        if (outs() !== 11'b1_111_0_0_1_0011) begin
            n_bad++; $display("FAIL rf_fault_hold: got %b want 11110000011", outs());
        end
        reinit = 1'b1;
        step();
        reinit = 1'b0;
        n_cmp++;
        if (outs() !== RESET_VEC) begin
            n_bad++; $display("FAIL rf_reinit: got %b want %b", outs(), RESET_VEC);
        end
        wait_for(0, 0, 100, n);
        n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL rf_reinit_hold: got %0d want 8", n); end
    endtask

    task automatic test_lock_loss_run();
        int n;
        locked = 1'b1;
        wait_for(4, 1, 200, n);
        n_cmp++; if (n !== 31) begin n_bad++; $display("FAIL ll_to_run: got %0d want 31", n); end
        locked = 1'b0;
        step();
        locked = 1'b1;
        step();
        n_cmp++;
        if (outs() !== 11'b0_000_1_0_0_0000) begin
            n_bad++; $display("FAIL ll_not_yet: got %b want 00001000000", outs());
        end
        step();
        n_cmp++;
        if (outs() !== 11'b0_111_0_1_0_0000) begin
            n_bad++; $display("FAIL ll_drop: got %b want 01110100000", outs());
        end
        step();
        n_cmp++;
        if ({mmcm_reset, lock_lost} !== 2'b10) begin
            n_bad++; $display("FAIL ll_after: got %b want 10", {mmcm_reset, lock_lost});
        end
        wait_for(0, 0, 100, n);
        n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL ll_hold: got %0d want 8", n); end
        wait_for(1, 0, 100, n);
        n_cmp++; if (n !== 17) begin n_bad++; $display("FAIL ll_rel1: got %0d want 17", n); end
        wait_for(4, 1, 100, n);
        n_cmp++; if (n !== 12) begin n_bad++; $display("FAIL ll_run: got %0d want 12", n); end
        n_cmp++;
        if (retry_cnt !== 4'd0) begin n_bad++; $display("FAIL ll_retry: got %0d want 0", retry_cnt); end
    endtask

    task automatic test_stab_glitch();
        int n;
        reinit = 1'b1;
        step();
        reinit = 1'b0;
        wait_for(0, 0, 100, n);
        n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL sg_hold: got %0d want 8", n); end
        repeat (11) step();
        locked = 1'b0;
        step();
        locked = 1'b1;
        n_cmp++;
        if ({rst_out1, retry_cnt} !== 5'b1_0000) begin
            n_bad++; $display("FAIL sg_stab: got %b want 10000", {rst_out1, retry_cnt});
        end
        wait_for(1, 0, 100, n);
        n_cmp++; if (n !== 19) begin n_bad++; $display("FAIL sg_rel1: got %0d want 19", n); end
        n_cmp++;
        if (retry_cnt !== 4'd0) begin n_bad++; $display("FAIL sg_retry: got %0d want 0", retry_cnt); end
    endtask

    task automatic test_loss_in_rel2();
        int n;
        wait_for(2, 0, 100, n);
        n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL r2_enter: got %0d want 4", n); end
        locked = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            step();
            n_cmp++;
            if ({rst_out1, rst_out2, rst_out3} !== 3'b001) begin
                n_bad++; $display("FAIL r2_hold%0d: got %b want 001", i, {rst_out1, rst_out2, rst_out3});
            end
        end
        step();
        n_cmp++;
        if ({rst_out1, rst_out2, rst_out3, lock_lost} !== 4'b1111) begin
            n_bad++;
            $display("FAIL r2_assert: got %b want 1111", {rst_out1, rst_out2, rst_out3, lock_lost});
        end
        wait_for(6, 1, 200, n);
        n_cmp++; if (n !== 73) begin n_bad++; $display("FAIL r2_retry: got %0d want 73", n); end
    endtask

    task automatic test_reset_reinit_rel3();
        int n;
        locked = 1'b1;
        wait_for(3, 0, 300, n);
        n_cmp++; if (n !== 33) begin n_bad++; $display("FAIL rr_rel3: got %0d want 33", n); end
        n_cmp++;
        if ({pll_ok, retry_cnt} !== 5'b0_0001) begin
            n_bad++; $display("FAIL rr_rel3_outs: got %b want 00001", {pll_ok, retry_cnt});
        end
        repeat (2) step();
        reset = 1'b1; reinit = 1'b1;
        step();
        n_cmp++;
        if (outs() !== RESET_VEC) begin
            n_bad++; $display("FAIL rr_reset_vals: got %b want %b", outs(), RESET_VEC);
        end
        reset = 1'b0; reinit = 1'b0;
        step();
        n_cmp++;
        if (outs() !== RESET_VEC) begin
            n_bad++; $display("FAIL rr_after: got %b want %b", outs(), RESET_VEC);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_power_up();
        test_retry_fault();
        test_lock_loss_run();
        test_stab_glitch();
        test_loss_in_rel2();
        test_reset_reinit_rel3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
